// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard sequencer: per-stage write enables and bubble controls for
// load-use hazards, MEM-stage redirects and multi-cycle RAM accesses, with a
// RAM wait watchdog that parks the pipeline in HALT.
// Optional macro HAZARD_PERF_COUNTERS_EN adds saturating performance counters.
module pipeline_hazard_controller #(
    parameter int unsigned WAIT_CNT_WIDTH = 8,
    parameter int unsigned WAIT_TIMEOUT   = 255,
    parameter int unsigned PERF_WIDTH     = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs1_address,
    input  logic [4:0] id_rs2_address,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic [4:0] ex_rd_address,
    input  logic       ex_reg_wren,
    input  logic       ex_is_load,
    input  logic       mem_ram_req,
    input  logic       ram_ready,
    input  logic       mem_redirect,
    output logic       pc_wren,
    output logic       if_id_wren,
    output logic       id_ex_wren,
    output logic       ex_mem_wren,
    output logic       mem_wb_wren,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       ex_mem_flush,
    output logic       mem_wb_flush,
    output logic       mem_timeout,
    output logic       stall_active
`ifdef HAZARD_PERF_COUNTERS_EN
    ,
    output logic [PERF_WIDTH-1:0] perf_stall_cycles,
    output logic [PERF_WIDTH-1:0] perf_flushes,
    output logic [PERF_WIDTH-1:0] perf_load_use
`endif
);

    typedef enum logic [1:0] {StRun, StMemWait, StHalt} state_t;

    state_t                    state_q, state_d;
    logic [WAIT_CNT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
    logic                      timeout_d;
    logic                      load_use;
    logic                      ram_stall;

    // Load-use match between the load in EX and the source operands in ID.
    always_comb begin
        load_use = ex_is_load && ex_reg_wren && (ex_rd_address != 5'd0) &&
                   ((id_uses_rs1 && (id_rs1_address == ex_rd_address)) ||
                    (id_uses_rs2 && (id_rs2_address == ex_rd_address)));
    end

    // Output decode and next-state logic; reset forces every control low.
    always_comb begin
        pc_wren      = 1'b0;
        if_id_wren   = 1'b0;
        id_ex_wren   = 1'b0;
        ex_mem_wren  = 1'b0;
        mem_wb_wren  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        stall_active = 1'b0;
        ram_stall    = 1'b0;
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        timeout_d    = mem_timeout;
        if (!reset) begin
            case (state_q)
                StHalt: begin
                    stall_active = 1'b1;
                end
                default: begin
                    // In MEM_WAIT the outstanding access is implied, so only ram_ready matters.
                    ram_stall = ((state_q == StMemWait) || mem_ram_req) && !ram_ready;
                    if (ram_stall) begin
                        mem_wb_wren  = 1'b1;
                        mem_wb_flush = 1'b1;
                        stall_active = 1'b1;
                        if (state_q == StRun) begin
                            state_d    = StMemWait;
                            wait_cnt_d = WAIT_CNT_WIDTH'(1);
                        end else if (wait_cnt_q == WAIT_CNT_WIDTH'(WAIT_TIMEOUT)) begin
                            state_d   = StHalt;
                            timeout_d = 1'b1;
                        end else begin
                            wait_cnt_d = wait_cnt_q + WAIT_CNT_WIDTH'(1);
                        end
                    end else begin
                        state_d      = StRun;
                        wait_cnt_d   = '0;
                        pc_wren      = 1'b1;
                        if_id_wren   = 1'b1;
                        id_ex_wren   = 1'b1;
                        ex_mem_wren  = 1'b1;
                        mem_wb_wren  = 1'b1;
                        if (mem_redirect) begin
                            if_id_flush  = 1'b1;
                            id_ex_flush  = 1'b1;
                            ex_mem_flush = 1'b1;
                        end else if (load_use) begin
                            pc_wren      = 1'b0;
                            if_id_wren   = 1'b0;
                            id_ex_flush  = 1'b1;
                            stall_active = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // FSM state, RAM wait counter and sticky timeout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StRun;
            wait_cnt_q  <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            mem_timeout <= timeout_d;
        end
    end

`ifdef HAZARD_PERF_COUNTERS_EN
    // Saturating event counters; if_id_flush is only raised by a redirect and
    // id_ex_flush without if_id_flush is only raised by a load-use bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_flushes      <= '0;
            perf_load_use     <= '0;
        end else begin
            if (stall_active && (perf_stall_cycles != '1)) begin
                perf_stall_cycles <= perf_stall_cycles + PERF_WIDTH'(1);
            end
            if (if_id_flush && (perf_flushes != '1)) begin
                perf_flushes <= perf_flushes + PERF_WIDTH'(1);
            end
            if (id_ex_flush && !if_id_flush && (perf_load_use != '1)) begin
                perf_load_use <= perf_load_use + PERF_WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench: a driver applies stimulus and pushes the reference model's
// expected controls; a monitor pops and compares on every falling edge.
module tb_pipeline_hazard_controller;

    localparam int unsigned TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1_address, id_rs2_address, ex_rd_address;
    logic       id_uses_rs1, id_uses_rs2, ex_reg_wren, ex_is_load;
    logic       mem_ram_req, ram_ready, mem_redirect;
    logic       pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren;
    logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic       mem_timeout, stall_active;
`ifdef HAZARD_PERF_COUNTERS_EN
    logic [31:0] perf_stall_cycles, perf_flushes, perf_load_use;
`endif

    pipeline_hazard_controller #(
        .WAIT_CNT_WIDTH(8),
        .WAIT_TIMEOUT  (TIMEOUT),
        .PERF_WIDTH    (32)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .id_rs1_address(id_rs1_address),
        .id_rs2_address(id_rs2_address),
        .id_uses_rs1   (id_uses_rs1),
        .id_uses_rs2   (id_uses_rs2),
        .ex_rd_address (ex_rd_address),
        .ex_reg_wren   (ex_reg_wren),
        .ex_is_load    (ex_is_load),
        .mem_ram_req   (mem_ram_req),
        .ram_ready     (ram_ready),
        .mem_redirect  (mem_redirect),
        .pc_wren       (pc_wren),
        .if_id_wren    (if_id_wren),
        .id_ex_wren    (id_ex_wren),
        .ex_mem_wren   (ex_mem_wren),
        .mem_wb_wren   (mem_wb_wren),
        .if_id_flush   (if_id_flush),
        .id_ex_flush   (id_ex_flush),
        .ex_mem_flush  (ex_mem_flush),
        .mem_wb_flush  (mem_wb_flush),
        .mem_timeout   (mem_timeout),
        .stall_active  (stall_active)
`ifdef HAZARD_PERF_COUNTERS_EN
        ,
        .perf_stall_cycles(perf_stall_cycles),
        .perf_flushes     (perf_flushes),
        .perf_load_use    (perf_load_use)
`endif
    );

    always #5 clk = ~clk;

    // Expected {pc,if_id,id_ex,ex_mem,mem_wb wren, if_id,id_ex,ex_mem,mem_wb flush, stall, timeout}
    logic [10:0] exp_q[$];
    int          exp_ps_q[$], exp_pf_q[$], exp_pl_q[$];
    int          checks = 0;
    int          passed = 0;

    // Reference model: counts consecutive RAM-stall cycles and a halted flag.
    bit m_halted;
    int m_stall_run;
    bit m_to;
    int m_ps, m_pf, m_pl;

    task automatic drive(input bit rst, input bit [4:0] rs1, input bit [4:0] rs2, input bit u1,
                         input bit u2, input bit [4:0] rd, input bit wr, input bit ld,
                         input bit req, input bit rdy, input bit redir);
        bit [4:0] wren;
        bit [3:0] fl;
        bit       st;
        bit       lu;
        @(posedge clk);
        #1;
        reset = rst; id_rs1_address = rs1; id_rs2_address = rs2; id_uses_rs1 = u1;
        id_uses_rs2 = u2; ex_rd_address = rd; ex_reg_wren = wr; ex_is_load = ld;
        mem_ram_req = req; ram_ready = rdy; mem_redirect = redir;
        wren = 5'b00000; fl = 4'b0000; st = 1'b0;
        lu = ld && wr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        if (rst) begin
            m_halted = 0; m_stall_run = 0; m_to = 0; m_ps = 0; m_pf = 0; m_pl = 0;
            exp_q.push_back(11'b0);
            exp_ps_q.push_back(0); exp_pf_q.push_back(0); exp_pl_q.push_back(0);
        end else begin
            if (m_halted) begin
                st = 1'b1;
            end else if ((m_stall_run > 0 || req) && !rdy) begin
                wren = 5'b00001; fl = 4'b0001; st = 1'b1;
            end else begin
                wren = 5'b11111;
                if (redir) fl = 4'b1110;
                else if (lu) begin wren = 5'b00111; fl = 4'b0100; st = 1'b1; end
            end
            exp_q.push_back({wren, fl, st, m_to});
            exp_ps_q.push_back(m_ps); exp_pf_q.push_back(m_pf); exp_pl_q.push_back(m_pl);
            // Advance the model to the state seen after this clock edge.
            if (!m_halted) begin
                if ((m_stall_run > 0 || req) && !rdy) begin
                    if (m_stall_run == TIMEOUT) begin m_halted = 1; m_to = 1; end
                    else m_stall_run++;
                end else begin
                    m_stall_run = 0;
                    if (redir) m_pf++;
                    else if (lu) m_pl++;
                end
            end
            if (st) m_ps++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 1, 2, 1, 1, 3, 1, 0, 0, 1, 0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    endtask

    // Monitor: compares DUT outputs against the queued expectations.
    always @(negedge clk) begin
        logic [10:0] act, e;
        int          eps, epf, epl;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            eps = exp_ps_q.pop_front();
            epf = exp_pf_q.pop_front();
            epl = exp_pl_q.pop_front();
            act = {pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren, if_id_flush,
                   id_ex_flush, ex_mem_flush, mem_wb_flush, stall_active, mem_timeout};
            checks++;
            if (act !== e) $display("FAIL controls @%0t: got %b expected %b", $time, act, e);
            else passed++;
`ifdef HAZARD_PERF_COUNTERS_EN
            checks++;
            if (perf_stall_cycles !== 32'(eps) || perf_flushes !== 32'(epf) ||
                perf_load_use !== 32'(epl))
                $display("FAIL perf @%0t: got %0d/%0d/%0d expected %0d/%0d/%0d", $time,
                         perf_stall_cycles, perf_flushes, perf_load_use, eps, epf, epl);
            else passed++;
`else
            if (eps < 0 || epf < 0 || epl < 0) $display("negative model count");
`endif
        end
    end

    initial begin
        int budget;
        reset = 1'b1; id_rs1_address = '0; id_rs2_address = '0; ex_rd_address = '0;
        id_uses_rs1 = 0; id_uses_rs2 = 0; ex_reg_wren = 0; ex_is_load = 0;
        mem_ram_req = 0; ram_ready = 1; mem_redirect = 0;
        m_halted = 0; m_stall_run = 0; m_to = 0; m_ps = 0; m_pf = 0; m_pl = 0;

        do_reset(3);
        idle(2);
        // Load-use on rs2, then the same with rd=x0.
        drive(0, 1, 5, 0, 1, 5, 1, 1, 0, 1, 0);
        idle(1);
        drive(0, 0, 0, 0, 1, 0, 1, 1, 0, 1, 0);
        idle(1);
        // Three not-ready cycles, then release.
        for (int i = 0; i < 3; i++) drive(0, 1, 2, 1, 1, 3, 1, 0, 1, 0, 0);
        drive(0, 1, 2, 1, 1, 3, 1, 0, 1, 1, 0);
        idle(1);
        // Redirect together with a load-use match.
        drive(0, 7, 1, 1, 0, 7, 1, 1, 0, 1, 1);
        idle(1);
        // Zero-wait access.
        drive(0, 1, 2, 1, 1, 3, 1, 0, 1, 1, 0);
        // Watchdog: never ready, HALT, then reset clears it.
        for (int i = 0; i < 9; i++) drive(0, 1, 2, 1, 1, 3, 1, 0, 1, 0, 0);
        do_reset(1);
        idle(2);
        // Counter scenario: 2 load-use, 1 redirect, 3-cycle wait.
        do_reset(1);
        drive(0, 4, 0, 1, 0, 4, 1, 1, 0, 1, 0);
        idle(1);
        drive(0, 0, 6, 0, 1, 6, 1, 1, 0, 1, 0);
        drive(0, 1, 2, 1, 1, 3, 1, 0, 0, 1, 1);
        for (int i = 0; i < 3; i++) drive(0, 1, 2, 1, 1, 3, 1, 0, 1, 0, 0);
        drive(0, 1, 2, 1, 1, 3, 1, 0, 0, 1, 0);
        idle(1);
        // Reset in the middle of a wait.
        for (int i = 0; i < 2; i++) drive(0, 1, 2, 1, 1, 3, 1, 0, 1, 0, 0);
        do_reset(1);
        idle(1);
        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 59) == 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom), 1'($urandom), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 3) != 0), 1'($urandom),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) == 0));
        end
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
